aes_core_scheduler: RTL and testbench

// - Shares one pipelined, non-stallable AES-128 core between NREQ requesters.
// - Each requester presents a key/plaintext job under a valid/ready handshake.
// - A round-robin arbiter issues at most one job per cycle into the core.
// - A tag pipeline returns each ciphertext to its originating requester.
// - Sits between the traffic sources and the AES top (clk, rst, state, key -> out).

---
 rtl/aes_sched_pkg.sv | 11 +
 rtl/aes_tag_pipe.sv | 18 +
 rtl/aes_core_scheduler.sv | 65 ++++++
 tb/tb_aes_core_scheduler.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// aes_sched_pkg: shared widths and tag type for the AES core scheduler
package aes_sched_pkg;
  localparam int AES_W = 128;
  localparam int NREQ_DFLT = 2;
  localparam int ID_W = $clog2(NREQ_DFLT);
  typedef logic [AES_W-1:0] aes_blk_t;
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;
endpackage

// File: rtl/aes_tag_pipe.sv
// aes_tag_pipe: free-running shift register carrying request tags alongside the AES core
module aes_tag_pipe
  import aes_sched_pkg::*;
#(
  parameter int DEPTH = 22
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);
  tag_t [DEPTH-1:0] pipe;
  // Shift every cycle; clearing drops every tag in flight
  always_ff @(posedge clk)
    if (!rst) pipe <= '0;
    else pipe <= {pipe[DEPTH-2:0], d};
  assign q = pipe[DEPTH-1];
endmodule

// File: rtl/aes_core_scheduler.sv
// aes_core_scheduler: round-robin sharing of one pipelined AES-128 core among NREQ requesters
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT,
  parameter int CORE_LAT = 21,
  parameter int MAX_INFLIGHT = 22
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ*AES_W-1:0]                req_key,
  input  logic [NREQ*AES_W-1:0]                req_state,
  output logic [AES_W-1:0]                     core_key,
  output logic [AES_W-1:0]                     core_state,
  input  logic [AES_W-1:0]                     core_out,
  output logic [NREQ-1:0]                      resp_valid,
  output logic [AES_W-1:0]                     resp_data,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]    inflight,
  output logic                                 busy
);
  localparam int CW = $clog2(MAX_INFLIGHT+1);
  logic [ID_W-1:0] ptr, win;
  logic found, hs;
  tag_t issue_tag, tail;
  // Round-robin search starting at ptr; first valid requester wins
  always_comb begin
    found = 1'b0;
    win = ptr;
    for (int k = 0; k < NREQ; k++)
      if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = ID_W'((int'(ptr) + k) % NREQ);
      end
  end
  assign hs = found && rst && inflight != CW'(MAX_INFLIGHT);
  assign req_ready = hs ? NREQ'(1) << win : '0;
  assign resp_valid = tail.valid ? NREQ'(1) << tail.id : '0;
  assign resp_data = core_out;
  assign busy = inflight != '0;
  // Register the winning job into the core; its tag enters the pipe as the core samples it
  always_ff @(posedge clk)
    if (!rst) begin
      ptr <= '0;
      core_key <= '0;
      core_state <= '0;
      issue_tag <= '0;
      inflight <= '0;
    end else begin
      issue_tag <= '{valid: hs, id: win};
      inflight <= inflight + CW'(hs) - CW'(tail.valid);
      if (hs) begin
        ptr <= (int'(win) == NREQ-1) ? '0 : win + 1'b1;
        core_key <= req_key[AES_W*win +: AES_W];
        core_state <= req_state[AES_W*win +: AES_W];
      end
    end
  aes_tag_pipe #(.DEPTH(CORE_LAT+1)) u_pipe (
    .clk(clk),
    .rst(rst),
    .d(issue_tag),
    .q(tail)
  );
endmodule

// File: tb/tb_aes_core_scheduler.sv
// tb_aes_core_scheduler: directed checks of arbitration, latency, throttling and reset drop
module tb_aes_core_scheduler;
  localparam int CORE_LAT = 21;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req_valid, req_ready, resp_valid, req_ready4, resp_valid4;
  logic [255:0] req_key, req_state;
  logic [127:0] core_key, core_state, core_out, resp_data, core_key4, core_state4, resp_data4;
  logic [4:0] inflight;
  logic [2:0] inflight4;
  logic busy, busy4;
  int checks = 0, failures = 0, cyc = 0;

  aes_core_scheduler dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_state(req_state), .core_key(core_key), .core_state(core_state),
    .core_out(core_out), .resp_valid(resp_valid), .resp_data(resp_data),
    .inflight(inflight), .busy(busy));

  aes_core_scheduler #(.MAX_INFLIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4),
    .req_key(req_key), .req_state(req_state), .core_key(core_key4), .core_state(core_state4),
    .core_out(128'h0), .resp_valid(resp_valid4), .resp_data(resp_data4),
    .inflight(inflight4), .busy(busy4));

  logic [7:0] sbox [256];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0, x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xt(x);
    end
    return p;
  endfunction
  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction
  function automatic logic [127:0] sub_b(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[127-8*i -: 8] = sbox[x[127-8*i -: 8]];
    return y;
  endfunction
  function automatic logic [127:0] shift_r(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
    return y;
  endfunction
  function automatic logic [127:0] mix_c(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 32] = {gm(a0,2)^gm(a1,3)^a2^a3, a0^gm(a1,2)^gm(a2,3)^a3,
                           a0^a1^gm(a2,2)^gm(a3,3), gm(a0,3)^a1^a2^gm(a3,2)};
    end
    return y;
  endfunction
  function automatic logic [127:0] aes(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc = 8'h01;
    logic [127:0] s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      s = shift_r(sub_b(s));
      if (r < 10) s = mix_c(s);
      s ^= {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return s;
  endfunction

  logic [127:0] cp [CORE_LAT+1];
  always @(posedge clk) begin
    cp[0] <= aes(core_key, core_state);
    for (int i = 1; i <= CORE_LAT; i++) cp[i] <= cp[i-1];
  end
  assign core_out = cp[CORE_LAT];
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int id; logic [127:0] ct; int cyc;} exp_t;
  exp_t q[$];
  typedef struct {logic [1:0] v; logic [1:0] rdy; logic [127:0] k0, s0, k1, s1;} vec_t;
  vec_t tbl [11];

  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic mon();
    exp_t e;
    if (!rst) q.delete();
    else begin
      chk("inflight_vs_model", inflight, q.size());
      if (resp_valid != 0) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp got=%b exp=00", resp_valid);
        end else begin
          e = q.pop_front();
          chk("resp_id", resp_valid, 2'b01 << e.id);
          chk("resp_data", resp_data, e.ct);
          chk("resp_latency", cyc - e.cyc, CORE_LAT + 2);
        end
      end
      for (int i = 0; i < 2; i++)
        if (req_valid[i] && req_ready[i])
          q.push_back('{i, aes(req_key[128*i +: 128], req_state[128*i +: 128]), cyc});
    end
  endtask
  task automatic tick();
    mon();
    @(negedge clk);
  endtask
  task automatic drive(input logic [1:0] v, input logic [127:0] k0, input logic [127:0] s0,
                       input logic [127:0] k1, input logic [127:0] s1);
    req_valid = v;
    req_key = {k1, k0};
    req_state = {s1, s0};
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [127:0] kat_k, kat_p, rk, rs;
    logic [7:0] inv;
    logic exp_r, rn;
    int n, m4, nacc;
    int acc[$];
    for (int a = 0; a < 256; a++) begin
      inv = 8'h0;
      for (int b = 1; b < 256; b++) if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      sbox[a] = inv ^ rl(inv,1) ^ rl(inv,2) ^ rl(inv,3) ^ rl(inv,4) ^ 8'h63;
    end
    kat_k = 128'h000102030405060708090a0b0c0d0e0f;
    kat_p = 128'h00112233445566778899aabbccddeeff;
    tbl[0] = '{2'b10, 2'b10, 0, 0, 0, 0};
    for (int i = 1; i <= 8; i++) tbl[i] = '{2'b11, (i % 2) ? 2'b01 : 2'b10, 0, 0, 0, 0};
    tbl[9] = '{2'b01, 2'b01, 0, 0, 0, 0};
    tbl[10] = '{2'b00, 2'b00, 0, 0, 0, 0};
    for (int i = 0; i < 11; i++) begin
      tbl[i].k0 = {4{32'(i) ^ 32'ha5a5_0000}};
      tbl[i].s0 = {4{32'(i * 7 + 3)}};
      tbl[i].k1 = {4{32'(i) + 32'h1234_5600}};
      tbl[i].s1 = ~{4{32'(i * 11)}};
    end
    drive(2'b00, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    drive(2'b11, kat_k, kat_p, kat_k, kat_p);
    chk("rst_ready", req_ready, 2'b00);
    tick();
    chk("rst_resp_valid", resp_valid, 2'b00);
    chk("rst_core_key", core_key, 0);
    chk("rst_core_state", core_state, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    drive(2'b01, kat_k, kat_p, 0, 0);
    chk("kat_ready", req_ready, 2'b01);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    chk("kat_busy", busy, 1);
    n = 0;
    while (resp_valid == 0 && n < 60) begin
      tick();
      n++;
    end
    chk("kat_latency", n, CORE_LAT + 1);
    chk("kat_resp_valid", resp_valid, 2'b01);
    chk("kat_ciphertext", resp_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    tick();
    chk("kat_idle_inflight", inflight, 0);
    chk("kat_idle_busy", busy, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].k0, tbl[i].s0, tbl[i].k1, tbl[i].s1);
      chk("arb_ready", req_ready, tbl[i].rdy);
      tick();
      if (tbl[i].rdy != 0) begin
        chk("issue_key", core_key, tbl[i].rdy[0] ? tbl[i].k0 : tbl[i].k1);
        chk("issue_state", core_state, tbl[i].rdy[0] ? tbl[i].s0 : tbl[i].s1);
      end
    end
    drive(2'b00, 0, 0, 0, 0);
    repeat (30) tick();
    chk("arb_drain_queue", q.size(), 0);
    chk("arb_drain_inflight", inflight, 0);
    for (int i = 0; i < 3; i++) begin
      drive(2'b01, {4{32'(i + 40)}}, {4{32'(i + 50)}}, 0, 0);
      chk("drop_accept", req_ready, 2'b01);
      tick();
    end
    drive(2'b00, 0, 0, 0, 0);
    repeat (5) tick();
    chk("drop_pre_inflight", inflight, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("drop_inflight", inflight, 0);
    chk("drop_busy", busy, 0);
    n = 0;
    repeat (30) begin
      if (resp_valid != 0) n++;
      tick();
    end
    chk("drop_no_resp", n, 0);
    rk = 128'hfeedface_0badf00d_12345678_9abcdef0;
    rs = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    drive(2'b11, rk, rs, kat_k, kat_p);
    chk("post_rst_ptr", req_ready, 2'b01);
    tick();
    drive(2'b00, 0, 0, 0, 0);
    n = 0;
    while (resp_valid == 0 && n < 60) begin
      tick();
      n++;
    end
    chk("post_rst_latency", n, CORE_LAT + 1);
    chk("post_rst_resp", resp_valid, 2'b01);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m4 = 0;
    nacc = 0;
    for (int t = 0; t < 70; t++) begin
      drive(2'b01, {4{32'(t) + 32'h7700}}, {4{32'(t * 3)}}, 0, 0);
      exp_r = m4 < 4;
      rn = acc.size() > 0 && acc[0] + CORE_LAT + 1 == cyc;
      chk("cap_ready", req_ready4[0], exp_r);
      chk("cap_inflight", inflight4, m4);
      chk("cap_resp", resp_valid4, {1'b0, rn});
      if (m4 > 0) chk("cap_busy", busy4, 1);
      if (rn) void'(acc.pop_front());
      if (exp_r) begin
        acc.push_back(cyc + 1);
        if (t < 22) nacc++;
      end
      m4 = m4 + int'(exp_r) - int'(rn);
      tick();
    end
    chk("cap_first_accepts", nacc, 4);
    drive(2'b00, 0, 0, 0, 0);
    repeat (40) tick();
    chk("final_queue_empty", q.size(), 0);
    chk("final_inflight", inflight, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
